seq_pattern_detector: RTL and testbench

Parametrised serial bit-pattern detector, successor to the fixed 1101 finder. Samples one bit per clock. Compares the most recent PAT_LEN bits against a runtime-loadable pattern. Supports overlapping and non-overlapping match modes and keeps a saturating match counter. Sits on a serial input stream and feeds a one-cycle match pulse plus a count to downstream control logic.

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/seq_sat_counter.sv | 22 ++
 rtl/seq_pattern_detector.sv | 58 +++++
 tb/tb_seq_pattern_detector.sv | 127 ++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and helpers for the serial pattern detector
package seq_det_pkg;
  localparam logic [3:0] DEF_PAT = 4'b1101;
  localparam int FILL_EMPTY = 0;
  function automatic int fill_w(input int pat_len);
    return (pat_len <= 2) ? 1 : $clog2(pat_len);
  endfunction
  function automatic int fill_primed(input int pat_len);
    return pat_len - 1;
  endfunction
endpackage

// File: rtl/seq_sat_counter.sv
// seq_sat_counter: saturating incrementer with synchronous clear and registered all-ones flag
module seq_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         sclr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);
  logic [W-1:0] nxt;
  always_comb nxt = sclr ? '0 : (inc && !sat) ? cnt + W'(1) : cnt;
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= nxt;
      sat <= &nxt;
    end
endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: serial detector matching the last PAT_LEN bits against a loadable pattern
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] RST_PAT = PAT_LEN'(DEF_PAT),
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               x,
  input  logic               en,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);
  localparam int FW = fill_w(PAT_LEN);
  localparam logic [FW-1:0] EMPTY = FW'(FILL_EMPTY);
  localparam logic [FW-1:0] PRIMED = FW'(fill_primed(PAT_LEN));
  logic [PAT_LEN-1:0] pattern, pat_n, window;
  logic [PAT_LEN-2:0] hist, hist_n;
  logic [FW-1:0] fill, fill_n;
  logic hit;
  always_comb begin
    window = {hist, x};
    hit    = en && !pat_load && (fill == PRIMED) && (window == pattern);
    pat_n  = pat_load ? pat_in : pattern;
    hist_n = pat_load ? '0 : en ? window[PAT_LEN-2:0] : hist;
    fill_n = pat_load ? EMPTY
           : !en ? fill
           : (hit && !overlap) ? EMPTY
           : (fill == PRIMED) ? PRIMED
           : fill + FW'(1);
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      pattern <= RST_PAT;
      hist    <= '0;
      fill    <= EMPTY;
      out     <= 1'b0;
    end else begin
      pattern <= pat_n;
      hist    <= hist_n;
      fill    <= fill_n;
      out     <= hit;
    end
  seq_sat_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .clr  (clr),
    .sclr (pat_load),
    .inc  (hit),
    .cnt  (match_cnt),
    .sat  (cnt_sat)
  );
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: table-driven check of the serial pattern detector plus async reset corners
module tb_seq_pattern_detector;
  logic clk = 1'b0, clr = 1'b0, x = 1'b0, en = 1'b0, overlap = 1'b0, pat_load = 1'b0;
  logic [3:0] pat_in = '0;
  logic out, sat, out2, sat2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(.PAT_LEN(4), .RST_PAT(4'b1101), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .x(x), .en(en), .overlap(overlap), .pat_load(pat_load),
    .pat_in(pat_in), .out(out), .match_cnt(cnt), .cnt_sat(sat)
  );
  seq_pattern_detector #(.PAT_LEN(4), .RST_PAT(4'b1101), .CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .x(x), .en(en), .overlap(overlap), .pat_load(pat_load),
    .pat_in(pat_in), .out(out2), .match_cnt(cnt2), .cnt_sat(sat2)
  );

  typedef struct {
    logic       en;
    logic       x;
    logic       ov;
    logic       pl;
    logic [3:0] pi;
    logic       eo;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic xx, input logic ov, input logic pl, input logic [3:0] pi);
    en = e; x = xx; overlap = ov; pat_load = pl; pat_in = pi;
    @(posedge clk);
    #1;
  endtask

  task automatic add_seq(input logic ov, input int n, input int b, input int o);
    for (int i = n - 1; i >= 0; i--) v.push_back('{1'b1, b[i], ov, 1'b0, 4'd0, o[i]});
  endtask

  task automatic add_gap(input logic ov, input int n, input int b);
    for (int i = n - 1; i >= 0; i--) v.push_back('{1'b0, b[i], ov, 1'b0, 4'd0, 1'b0});
  endtask

  task automatic add_load(input logic [3:0] pi, input logic ov, input logic e, input logic xx);
    v.push_back('{e, xx, ov, 1'b1, pi, 1'b0});
  endtask

  initial begin
    int ecnt;
    add_seq(0, 8, 'b00101101, 'b00000001);
    add_seq(0, 1, 'b0, 'b0);
    add_load(4'b1101, 0, 1, 0);
    add_seq(1, 7, 'b1101101, 'b0001001);
    add_load(4'b1101, 0, 1, 0);
    add_seq(0, 7, 'b1101101, 'b0001000);
    add_load(4'b1101, 0, 1, 1);
    add_seq(0, 2, 'b11, 'b00);
    add_gap(0, 3, 'b010);
    add_seq(0, 2, 'b01, 'b01);
    add_load(4'b1101, 1, 1, 0);
    add_seq(1, 7, 'b1101101, 'b0001001);
    add_load(4'b0110, 0, 1, 1);
    add_seq(0, 4, 'b0110, 'b0001);
    add_seq(0, 4, 'b1101, 'b0000);
    add_load(4'b1111, 1, 0, 1);
    add_seq(1, 8, 'b11111111, 'b00011111);
    add_seq(1, 1, 'b0, 'b0);

    @(posedge clk);
    #1;
    chk("reset_out", out, 0);
    chk("reset_cnt", cnt, 0);
    chk("reset_sat", sat, 0);
    chk("reset_cnt2", cnt2, 0);
    #2 clr = 1'b1;

    ecnt = 0;
    foreach (v[i]) begin
      step(v[i].en, v[i].x, v[i].ov, v[i].pl, v[i].pi);
      ecnt = v[i].pl ? 0 : (v[i].eo && ecnt < 255) ? ecnt + 1 : ecnt;
      chk($sformatf("row%0d_out", i), out, v[i].eo);
      chk($sformatf("row%0d_cnt", i), cnt, ecnt);
      chk($sformatf("row%0d_sat", i), sat, ecnt == 255);
      chk($sformatf("row%0d_out2", i), out2, v[i].eo);
      chk($sformatf("row%0d_cnt2", i), cnt2, ecnt > 3 ? 3 : ecnt);
      chk($sformatf("row%0d_sat2", i), sat2, ecnt >= 3);
    end

    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("pre_clr_out", out, 0);
    chk("pre_clr_cnt", cnt, 5);
    chk("pre_clr_sat2", sat2, 1);
    #2 clr = 1'b0;
    #1;
    chk("async_clr_cnt", cnt, 0);
    chk("async_clr_cnt2", cnt2, 0);
    chk("async_clr_sat2", sat2, 0);
    #2 clr = 1'b1;
    step(1, 1, 0, 0, 0);
    chk("post_clr_bit1", out, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("post_clr_bit3", out, 0);
    step(1, 1, 0, 0, 0);
    chk("post_clr_match_out", out, 1);
    chk("post_clr_match_cnt", cnt, 1);
    #2 clr = 1'b0;
    #1;
    chk("async_clr_pulse_out", out, 0);
    chk("async_clr_pulse_cnt", cnt, 0);
    #2 clr = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
